// File: rtl/wb_mux_pkg.sv
// Shared Wishbone widths, mux FSM states and the base/mask address decode
// used by the N-port SRAM mux.
package wb_mux_pkg;

   localparam int WB_DW     = 32;
   localparam int WB_AW     = 32;
   localparam int WB_SW     = 4;
   localparam int MAX_PORTS = 16;
   localparam int IDX_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP,
      ST_ERR
   } wb_state_e;

   typedef struct packed {
      logic             mapped;
      logic [IDX_W-1:0] idx;
   } wb_decode_t;

   // Scans from the top index down so that the lowest matching port wins.
   function automatic wb_decode_t wb_decode(
      input logic [WB_AW*MAX_PORTS-1:0] bases,
      input logic [WB_AW*MAX_PORTS-1:0] masks,
      input logic [WB_AW-1:0]           adr,
      input int                         num_ports
   );
      wb_decode_t res;
      res = '0;
      for (int i = MAX_PORTS - 1; i >= 0; i--) begin
         if ((i < num_ports) &&
             ((adr & masks[WB_AW*i +: WB_AW]) == bases[WB_AW*i +: WB_AW])) begin
            res.mapped = 1'b1;
            res.idx    = IDX_W'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational priority address decode: reports whether the address hits
// any port window and, if so, the lowest-indexed matching port.
module wb_addr_decoder
   import wb_mux_pkg::*;
#(
   parameter int                      NUM_PORTS  = 5,
   parameter logic [32*NUM_PORTS-1:0] BASE_ADDRS = {32'h3000_2c00, 32'h3000_1c00, 32'h3000_0c00,
                                                    32'h3000_0400, 32'h3000_0000},
   parameter logic [32*NUM_PORTS-1:0] MASKS      = {32'hffff_fc00, 32'hffff_fe00, 32'hffff_fc00,
                                                    32'hffff_fe00, 32'hffff_ff00}
) (
   input  logic [WB_AW-1:0] adr,
   output logic             mapped,
   output logic [IDX_W-1:0] port_idx
);

   // Unused upper slots are zero but excluded by the port-count bound.
   localparam logic [WB_AW*MAX_PORTS-1:0] BASE_PAD = (WB_AW*MAX_PORTS)'(BASE_ADDRS);
   localparam logic [WB_AW*MAX_PORTS-1:0] MASK_PAD = (WB_AW*MAX_PORTS)'(MASKS);

   wb_decode_t dec;

   assign dec      = wb_decode(BASE_PAD, MASK_PAD, adr, NUM_PORTS);
   assign mapped   = dec.mapped;
   assign port_idx = dec.idx;

endmodule

// File: rtl/wishbone_ram_mux_n.sv
// Wishbone B4 classic mux from one upstream port to NUM_PORTS SRAM wrappers,
// with a registered transaction FSM, unmapped-address error and hung-slave timeout.
module wishbone_ram_mux_n
   import wb_mux_pkg::*;
#(
   parameter int                      NUM_PORTS      = 5,
   parameter logic [32*NUM_PORTS-1:0] BASE_ADDRS     = {32'h3000_2c00, 32'h3000_1c00, 32'h3000_0c00,
                                                        32'h3000_0400, 32'h3000_0000},
   parameter logic [32*NUM_PORTS-1:0] MASKS          = {32'hffff_fc00, 32'hffff_fe00, 32'hffff_fc00,
                                                        32'hffff_fe00, 32'hffff_ff00},
   parameter int                      TIMEOUT_CYCLES = 255,
   parameter logic [31:0]             ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         wbs_ufp_stb_i,
   input  logic                         wbs_ufp_cyc_i,
   input  logic                         wbs_ufp_we_i,
   input  logic [WB_SW-1:0]             wbs_ufp_sel_i,
   input  logic [WB_AW-1:0]             wbs_ufp_adr_i,
   input  logic [WB_DW-1:0]             wbs_ufp_dat_i,
   output logic                         wbs_ufp_ack_o,
   output logic                         wbs_ufp_err_o,
   output logic [WB_DW-1:0]             wbs_ufp_dat_o,
   output logic [WB_AW-1:0]             wbs_dn_adr_o,
   output logic [NUM_PORTS-1:0]         wbs_dn_stb_o,
   output logic [NUM_PORTS-1:0]         wbs_dn_cyc_o,
   output logic [NUM_PORTS-1:0]         wbs_dn_we_o,
   output logic [WB_SW*NUM_PORTS-1:0]   wbs_dn_sel_o,
   output logic [WB_DW*NUM_PORTS-1:0]   wbs_dn_dat_o,
   input  logic [WB_DW*NUM_PORTS-1:0]   wbs_dn_dat_i,
   input  logic [NUM_PORTS-1:0]         wbs_dn_ack_i
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   wb_state_e        state_q, state_d;
   logic [IDX_W-1:0] port_q;
   logic [IDX_W-1:0] dec_idx;
   logic             dec_mapped;
   logic [WB_AW-1:0] adr_q;
   logic             we_q;
   logic [WB_SW-1:0] sel_q;
   logic [WB_DW-1:0] wdat_q;
   logic [WB_DW-1:0] rdat_q;
   logic [CNT_W-1:0] cnt_q;
   logic             req_start;
   logic             port_ack;
   logic [WB_DW-1:0] port_rdat;

   wb_addr_decoder #(
      .NUM_PORTS (NUM_PORTS),
      .BASE_ADDRS(BASE_ADDRS),
      .MASKS     (MASKS)
   ) u_dec (
      .adr     (wbs_ufp_adr_i),
      .mapped  (dec_mapped),
      .port_idx(dec_idx)
   );

   assign req_start = wbs_ufp_cyc_i & wbs_ufp_stb_i;

   // Only the latched port's ack and read data are ever looked at.
   always_comb begin
      port_ack  = 1'b0;
      port_rdat = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (port_q == IDX_W'(i)) begin
            port_ack  = wbs_dn_ack_i[i];
            port_rdat = wbs_dn_dat_i[WB_DW*i +: WB_DW];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_start) state_d = dec_mapped ? ST_REQ : ST_ERR;
         end
         ST_REQ: begin
            // A master that drops cyc has abandoned the cycle; that outranks a same-cycle ack.
            if (!wbs_ufp_cyc_i)                                  state_d = ST_IDLE;
            else if (port_ack)                                   state_d = ST_RESP;
            else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) state_d = ST_ERR;
         end
         ST_RESP: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         port_q  <= '0;
         adr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && req_start && dec_mapped) begin
            port_q <= dec_idx;
            adr_q  <= wbs_ufp_adr_i;
            cnt_q  <= '0;
         end else if (state_q == ST_REQ) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Payload registers are only observed through REQ/RESP qualified paths.
   always_ff @(posedge wb_clk_i) begin
      if (state_q == ST_IDLE && req_start && dec_mapped) begin
         we_q   <= wbs_ufp_we_i;
         sel_q  <= wbs_ufp_sel_i;
         wdat_q <= wbs_ufp_dat_i;
      end
      if (state_q == ST_REQ && port_ack) rdat_q <= port_rdat;
   end

   always_comb begin
      wbs_dn_stb_o = '0;
      wbs_dn_cyc_o = '0;
      wbs_dn_we_o  = '0;
      wbs_dn_sel_o = '0;
      wbs_dn_dat_o = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (state_q == ST_REQ && port_q == IDX_W'(i)) begin
            wbs_dn_stb_o[i]                   = 1'b1;
            wbs_dn_cyc_o[i]                   = 1'b1;
            wbs_dn_we_o[i]                    = we_q;
            wbs_dn_sel_o[WB_SW*i +: WB_SW]    = sel_q;
            wbs_dn_dat_o[WB_DW*i +: WB_DW]    = wdat_q;
         end
      end
   end

   assign wbs_dn_adr_o  = adr_q;
   assign wbs_ufp_ack_o = (state_q == ST_RESP);
   assign wbs_ufp_err_o = (state_q == ST_ERR);
   assign wbs_ufp_dat_o = (state_q == ST_RESP) ? rdat_q :
                          (state_q == ST_ERR)  ? ERR_DATA : '0;

endmodule
